// File: rtl/dcache_wr_buffer_pkg.sv
// -----------------------------------------------------------------------------
// dcache_wr_buffer_pkg
// Definitions shared by the data-cache write buffer and the cache/AXI bridge
// write port:
//   - write-type codes carried on in_wr_type / wr_type
//   - line-offset width (a cache line is 16 bytes)
//   - widths of the entry fields
//   - is_line() helper for classifying an entry type
// -----------------------------------------------------------------------------
package dcache_wr_buffer_pkg;

  localparam int WR_TYPE_W  = 3;
  localparam int WR_STRB_W  = 4;
  localparam int WR_DATA_W  = 128;
  localparam int LINE_OFF_W = 4;

  localparam logic [WR_TYPE_W-1:0] WR_BYTE = 3'b000;
  localparam logic [WR_TYPE_W-1:0] WR_HALF = 3'b001;
  localparam logic [WR_TYPE_W-1:0] WR_WORD = 3'b010;
  localparam logic [WR_TYPE_W-1:0] WR_LINE = 3'b100;

  localparam logic [WR_STRB_W-1:0] WR_STRB_ALL = 4'hF;

  // True when the type code denotes a full-line write
  function automatic logic is_line(input logic [WR_TYPE_W-1:0] wr_type);
    return (wr_type == WR_LINE);
  endfunction

endpackage

// File: rtl/dcache_wr_buffer_match.sv
// -----------------------------------------------------------------------------
// dcache_wrbuf_match
// Comparator array for the write-buffer lookup port. Each valid entry whose
// line tag equals the lookup tag is a match.
//   ent_valid   : per-entry valid bits
//   ent_type    : per-entry write type
//   ent_tag     : per-entry line tag (address bits above the line offset)
//   tail_ptr    : next slot to be written; the entry just below it is youngest
//   lk_valid    : lookup enable
//   lk_tag      : lookup line tag
//   line_oh     : one-hot of the youngest matching line entry (0 if none)
//   nonline_hit : at least one matching non-line entry
// -----------------------------------------------------------------------------
module dcache_wrbuf_match
  import dcache_wr_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 28,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                ent_valid,
  input  logic [DEPTH-1:0][WR_TYPE_W-1:0] ent_type,
  input  logic [DEPTH-1:0][TAG_W-1:0]     ent_tag,
  input  logic [PTR_W-1:0]                tail_ptr,
  input  logic                            lk_valid,
  input  logic [TAG_W-1:0]                lk_tag,
  output logic [DEPTH-1:0]                line_oh,
  output logic                            nonline_hit
);

  // Scan from youngest (tail-1) to oldest; the first line match claims the one-hot
  always_comb begin
    logic [PTR_W-1:0] idx_s;
    logic             match_s;
    logic             found_s;
    line_oh     = '0;
    nonline_hit = 1'b0;
    found_s     = 1'b0;
    idx_s       = '0;
    match_s     = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_s          = tail_ptr - PTR_W'(k) - PTR_W'(1);
      match_s        = lk_valid && ent_valid[idx_s] && (ent_tag[idx_s] == lk_tag);
      line_oh[idx_s] = line_oh[idx_s] | (match_s && is_line(ent_type[idx_s]) && !found_s);
      found_s        = found_s | (match_s && is_line(ent_type[idx_s]));
      nonline_hit    = nonline_hit | (match_s && !is_line(ent_type[idx_s]));
    end
  end

endmodule

// File: rtl/dcache_wr_buffer.sv
// -----------------------------------------------------------------------------
// dcache_wr_buffer
// In-order write buffer between the data cache and the bridge write port.
// Holds dirty-line evictions and uncached stores in a DEPTH-entry circular
// FIFO and drains them one at a time to the bridge.
//   aclk, areset      : clock, synchronous active-high reset
//   in_wr_*           : write request from the cache (push side)
//   lk_*              : address lookup (forwarding / stall detection)
//   wr_*              : head entry presented to the bridge (pop side)
//   empty, count      : occupancy status
// Build option DCACHE_WRBUF_FWD_EN: when defined, a line match returns the
// youngest matching line on lk_hit/lk_data; when undefined, a line match is
// reported on lk_stall and lk_hit/lk_data are held at zero.
// -----------------------------------------------------------------------------
module dcache_wr_buffer
  import dcache_wr_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       in_wr_req,
  input  logic [WR_TYPE_W-1:0]       in_wr_type,
  input  logic [ADDR_W-1:0]          in_wr_addr,
  input  logic [WR_STRB_W-1:0]       in_wr_wstrb,
  input  logic [WR_DATA_W-1:0]       in_wr_data,
  output logic                       in_wr_rdy,
  input  logic                       lk_valid,
  input  logic [ADDR_W-1:0]          lk_addr,
  output logic                       lk_hit,
  output logic                       lk_stall,
  output logic [WR_DATA_W-1:0]       lk_data,
  output logic                       wr_req,
  output logic [WR_TYPE_W-1:0]       wr_type,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [WR_STRB_W-1:0]       wr_wstrb,
  output logic [WR_DATA_W-1:0]       wr_data,
  input  logic                       wr_rdy,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int TAG_W = ADDR_W - LINE_OFF_W;

  logic [DEPTH-1:0]                ent_valid_r;
  logic [DEPTH-1:0][WR_TYPE_W-1:0] ent_type_r;
  logic [DEPTH-1:0][ADDR_W-1:0]    ent_addr_r;
  logic [DEPTH-1:0][WR_STRB_W-1:0] ent_strb_r;
  logic [DEPTH-1:0][WR_DATA_W-1:0] ent_data_r;
  logic [PTR_W-1:0]                head_r;
  logic [PTR_W-1:0]                tail_r;
  logic [CNT_W-1:0]                count_r;

  logic                            full_s;
  logic                            empty_s;
  logic                            push_s;
  logic                            pop_s;
  logic [DEPTH-1:0][TAG_W-1:0]     ent_tag_s;
  logic [DEPTH-1:0]                line_oh_s;
  logic                            nonline_hit_s;
  logic [LINE_OFF_W-1:0]           lk_off_unused_s;

  assign full_s          = (count_r == CNT_W'(DEPTH));
  assign empty_s         = (count_r == CNT_W'(0));
  assign push_s          = in_wr_req && !full_s;
  assign pop_s           = wr_rdy && !empty_s;
  assign in_wr_rdy       = !full_s;
  assign empty           = empty_s;
  assign count           = count_r;
  // Lookup compares whole lines only; the byte offset is deliberately ignored
  assign lk_off_unused_s = lk_addr[LINE_OFF_W-1:0];

  // FIFO storage, pointers and occupancy; popped slots are zeroed
  always_ff @(posedge aclk) begin
    if (areset) begin
      ent_valid_r <= '0;
      ent_type_r  <= '0;
      ent_addr_r  <= '0;
      ent_strb_r  <= '0;
      ent_data_r  <= '0;
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
    end else begin
      // A push never targets the head slot while it is being popped: that
      // would require a full buffer, and a full buffer refuses pushes.
      if (push_s) begin
        ent_valid_r[tail_r] <= 1'b1;
        ent_type_r[tail_r]  <= in_wr_type;
        ent_addr_r[tail_r]  <= in_wr_addr;
        ent_strb_r[tail_r]  <= is_line(in_wr_type) ? WR_STRB_ALL : in_wr_wstrb;
        ent_data_r[tail_r]  <= in_wr_data;
        tail_r              <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        ent_valid_r[head_r] <= 1'b0;
        ent_type_r[head_r]  <= '0;
        ent_addr_r[head_r]  <= '0;
        ent_strb_r[head_r]  <= '0;
        ent_data_r[head_r]  <= '0;
        head_r              <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry presented to the bridge, forced to zero when nothing is queued
  always_comb begin
    wr_req = !empty_s;
    if (!empty_s) begin
      wr_type  = ent_type_r[head_r];
      wr_addr  = ent_addr_r[head_r];
      wr_wstrb = ent_strb_r[head_r];
      wr_data  = ent_data_r[head_r];
    end else begin
      wr_type  = '0;
      wr_addr  = '0;
      wr_wstrb = '0;
      wr_data  = '0;
    end
  end

  // Extract line tags for the comparator array
  always_comb begin
    ent_tag_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_tag_s[i] = ent_addr_r[i][ADDR_W-1:LINE_OFF_W];
    end
  end

  dcache_wrbuf_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .PTR_W (PTR_W)
  ) u_match (
    .ent_valid   (ent_valid_r),
    .ent_type    (ent_type_r),
    .ent_tag     (ent_tag_s),
    .tail_ptr    (tail_r),
    .lk_valid    (lk_valid),
    .lk_tag      (lk_addr[ADDR_W-1:LINE_OFF_W]),
    .line_oh     (line_oh_s),
    .nonline_hit (nonline_hit_s)
  );

`ifdef DCACHE_WRBUF_FWD_EN
  // Forward the youngest matching line through an AND-OR mux
  always_comb begin
    lk_hit   = |line_oh_s;
    lk_stall = nonline_hit_s;
    lk_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_data = lk_data | (ent_data_r[i] & {WR_DATA_W{line_oh_s[i]}});
    end
  end
`else
  // No forwarding path: any match stalls the cache until the entry drains
  always_comb begin
    lk_hit   = 1'b0;
    lk_stall = nonline_hit_s | (|line_oh_s);
    lk_data  = '0;
  end
`endif

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// -----------------------------------------------------------------------------
// tb_dcache_wr_buffer
// Directed plus short random stimulus for dcache_wr_buffer. A queue holds the
// entries the bench expects to be buffered; every cycle the DUT head, status
// and lookup outputs are compared against that queue.
// -----------------------------------------------------------------------------
module tb_dcache_wr_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  localparam logic [2:0] T_BYTE = 3'b000;
  localparam logic [2:0] T_HALF = 3'b001;
  localparam logic [2:0] T_WORD = 3'b010;
  localparam logic [2:0] T_LINE = 3'b100;

  typedef struct packed {
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [3:0]   strb;
    logic [127:0] data;
  } ent_t;

  logic         aclk;
  logic         areset;
  logic         in_wr_req;
  logic [2:0]   in_wr_type;
  logic [31:0]  in_wr_addr;
  logic [3:0]   in_wr_wstrb;
  logic [127:0] in_wr_data;
  logic         in_wr_rdy;
  logic         lk_valid;
  logic [31:0]  lk_addr;
  logic         lk_hit;
  logic         lk_stall;
  logic [127:0] lk_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         empty;
  logic [2:0]   count;

  ent_t q[$];
  bit   model_valid = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  dcache_wr_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .in_wr_req   (in_wr_req),
    .in_wr_type  (in_wr_type),
    .in_wr_addr  (in_wr_addr),
    .in_wr_wstrb (in_wr_wstrb),
    .in_wr_data  (in_wr_data),
    .in_wr_rdy   (in_wr_rdy),
    .lk_valid    (lk_valid),
    .lk_addr     (lk_addr),
    .lk_hit      (lk_hit),
    .lk_stall    (lk_stall),
    .lk_data     (lk_data),
    .wr_req      (wr_req),
    .wr_type     (wr_type),
    .wr_addr     (wr_addr),
    .wr_wstrb    (wr_wstrb),
    .wr_data     (wr_data),
    .wr_rdy      (wr_rdy),
    .empty       (empty),
    .count       (count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model, then advance the model by one edge.
  task automatic tick();
    ent_t         e;
    logic         eh;
    logic         es;
    logic [127:0] ed;
    bit           acc;
    bit           pp;
    #1;
    if (model_valid) begin
      chk("count",     128'(count),     128'(q.size()));
      chk("empty",     128'(empty),     128'(q.size() == 0));
      chk("in_wr_rdy", 128'(in_wr_rdy), 128'(q.size() < DEPTH));
      chk("wr_req",    128'(wr_req),    128'(q.size() != 0));
      e = (q.size() != 0) ? q[0] : '0;
      chk("wr_type",  128'(wr_type),  128'(e.typ));
      chk("wr_addr",  128'(wr_addr),  128'(e.addr));
      chk("wr_wstrb", 128'(wr_wstrb), 128'(e.strb));
      chk("wr_data",  wr_data,        e.data);
      eh = 1'b0; es = 1'b0; ed = '0;
      if (lk_valid) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].addr[31:4] == lk_addr[31:4]) begin
            if (q[i].typ == T_LINE) begin
              if (!eh) ed = q[i].data;
              eh = 1'b1;
            end else begin
              es = 1'b1;
            end
          end
        end
      end
`ifndef DCACHE_WRBUF_FWD_EN
      es = es | eh;
      eh = 1'b0;
      ed = '0;
`endif
      chk("lk_hit",   128'(lk_hit),   128'(eh));
      chk("lk_stall", 128'(lk_stall), 128'(es));
      chk("lk_data",  lk_data,        ed);
    end
    acc = model_valid && !areset && in_wr_req && (q.size() < DEPTH);
    pp  = model_valid && !areset && wr_rdy && (q.size() != 0);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back('{typ: in_wr_type, addr: in_wr_addr,
                           strb: (in_wr_type == T_LINE) ? 4'hF : in_wr_wstrb,
                           data: in_wr_data});
    if (areset) begin
      q.delete();
      model_valid = 1'b1;
    end
    @(negedge aclk);
  endtask

  task automatic set_wr(input logic req, input logic [2:0] t, input logic [31:0] a,
                        input logic [3:0] s, input logic [127:0] d);
    in_wr_req   = req;
    in_wr_type  = t;
    in_wr_addr  = a;
    in_wr_wstrb = s;
    in_wr_data  = d;
  endtask

  initial begin
    logic [31:0] bases [4];
    logic [2:0]  types [4];
    bases[0] = 32'h2000_0010; bases[1] = 32'h3000_0000;
    bases[2] = 32'h4000_0020; bases[3] = 32'h5000_0030;
    types[0] = T_BYTE; types[1] = T_HALF; types[2] = T_WORD; types[3] = T_LINE;

    // Reset with a write request held: nothing may be pushed
    areset   = 1'b1;
    wr_rdy   = 1'b0;
    lk_valid = 1'b0;
    lk_addr  = 32'h0;
    set_wr(1'b1, T_WORD, 32'h0000_0100, 4'hF, 128'h55);
    tick();
    tick();
    areset = 1'b0;
    set_wr(1'b0, T_BYTE, 32'h0, 4'h0, 128'h0);
    tick();

    // Single line push, strobe forced to F, then drained
    set_wr(1'b1, T_LINE, 32'h1000_0040, 4'h3, 128'h0123);
    tick();
    set_wr(1'b0, T_BYTE, 32'h0, 4'h0, 128'h0);
    tick();
    wr_rdy = 1'b1;
    tick();
    tick();

    // Five word stores into four slots, drain, then a second fill to wrap pointers
    for (int pass = 0; pass < 2; pass++) begin
      wr_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
        set_wr(1'b1, T_WORD, 32'h0000_0100 + 32'(pass * 64 + i * 4), 4'(i + 1), 128'(i + 16 * pass));
        tick();
      end
      set_wr(1'b0, T_BYTE, 32'h0, 4'h0, 128'h0);
      wr_rdy = 1'b1;
      for (int i = 0; i < 5; i++) tick();
    end

    // Full: push refused while pop proceeds; half-full: push and pop together
    wr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, T_HALF, 32'h0000_0200 + 32'(i * 2), 4'h3, 128'(i + 32'h40));
      tick();
    end
    set_wr(1'b1, T_BYTE, 32'h0000_0300, 4'h1, 128'h77);
    wr_rdy = 1'b1;
    tick();
    set_wr(1'b0, T_BYTE, 32'h0, 4'h0, 128'h0);
    tick();
    set_wr(1'b1, T_BYTE, 32'h0000_0304, 4'h2, 128'h78);
    tick();
    set_wr(1'b0, T_BYTE, 32'h0, 4'h0, 128'h0);
    for (int i = 0; i < 4; i++) tick();

    // Lookup: two lines at the same address, then a word store
    wr_rdy = 1'b0;
    set_wr(1'b1, T_LINE, 32'h2000_0010, 4'h0, 128'hAAAA_0000_0000_0000_0000_0000_0000_0001);
    tick();
    set_wr(1'b1, T_LINE, 32'h2000_0010, 4'h0, 128'hBBBB_0000_0000_0000_0000_0000_0000_0002);
    tick();
    set_wr(1'b1, T_WORD, 32'h3000_0004, 4'hF, 128'hCAFE);
    tick();
    // Line being pushed this cycle must not match its own lookup
    set_wr(1'b1, T_LINE, 32'h4000_0020, 4'h0, 128'hDD);
    lk_valid = 1'b1;
    lk_addr  = 32'h4000_0024;
    tick();
    set_wr(1'b0, T_BYTE, 32'h0, 4'h0, 128'h0);
    lk_addr = 32'h2000_001C;
    tick();
    lk_addr = 32'h3000_0008;
    tick();
    lk_addr = 32'h2000_0010;
    tick();
    // Head entry participates in lookup while being popped
    wr_rdy = 1'b1;
    tick();
    tick();
    lk_valid = 1'b0;
    tick();
    tick();
    tick();

    // Random mix of pushes, pops and lookups over a few line addresses
    for (int i = 0; i < 60; i++) begin
      set_wr(1'($urandom_range(0, 1)), types[$urandom_range(0, 3)],
             bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), {4{32'($urandom)}});
      wr_rdy   = 1'($urandom_range(0, 1));
      lk_valid = 1'($urandom_range(0, 1));
      lk_addr  = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15));
      tick();
    end

    // Reset with three entries queued discards them
    lk_valid = 1'b0;
    wr_rdy   = 1'b0;
    set_wr(1'b0, T_BYTE, 32'h0, 4'h0, 128'h0);
    tick();
    while (q.size() > 0) begin
      wr_rdy = 1'b1;
      tick();
    end
    wr_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, T_WORD, 32'h0000_0400 + 32'(i * 4), 4'hF, 128'(i));
      tick();
    end
    set_wr(1'b1, T_WORD, 32'h0000_0500, 4'hF, 128'h99);
    wr_rdy = 1'b1;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    set_wr(1'b0, T_BYTE, 32'h0, 4'h0, 128'h0);
    wr_rdy = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
